// File: rtl/interrupt_dispatch_if.sv
// Signal bundle between the interrupt dispatcher and the CPU core / IRQ sources.
// Member names match the dispatcher's historical port names.
interface interrupt_dispatch_if;
  logic        I_MCYCLE_EN;
  logic [4:0]  I_IRQ;
  logic [15:0] I_CPU_ADDR;
  logic [7:0]  I_CPU_DATA;
  logic        I_MEM_WE_L;
  logic        I_BOUNDARY;
  logic        I_EI;
  logic        I_DI;
  logic        I_RETI;

  logic [7:0]  O_IF;
  logic [7:0]  O_IE;
  logic        O_IME;
  logic        O_WAKE;
  logic        O_CPU_HOLD;
  logic        O_SP_DEC;
  logic        O_PUSH_HI;
  logic        O_PUSH_LO;
  logic        O_LOAD_PC;
  logic [15:0] O_VECTOR;
  logic [4:0]  O_ACK;

  // Dispatcher side
  modport slave (
    input  I_MCYCLE_EN, I_IRQ, I_CPU_ADDR, I_CPU_DATA, I_MEM_WE_L,
           I_BOUNDARY, I_EI, I_DI, I_RETI,
    output O_IF, O_IE, O_IME, O_WAKE, O_CPU_HOLD, O_SP_DEC, O_PUSH_HI,
           O_PUSH_LO, O_LOAD_PC, O_VECTOR, O_ACK
  );

  // CPU core / request source side
  modport master (
    output I_MCYCLE_EN, I_IRQ, I_CPU_ADDR, I_CPU_DATA, I_MEM_WE_L,
           I_BOUNDARY, I_EI, I_DI, I_RETI,
    input  O_IF, O_IE, O_IME, O_WAKE, O_CPU_HOLD, O_SP_DEC, O_PUSH_HI,
           O_PUSH_LO, O_LOAD_PC, O_VECTOR, O_ACK
  );
endinterface

// File: rtl/interrupt_dispatch.sv
// GBC interrupt controller: owns IF/IE/IME, arbitrates pending requests
// (lowest bit first) and sequences the 5-M-cycle dispatch
// WAIT -> SPDEC -> PUSHHI -> PUSHLO -> JUMP with registered datapath strobes.
module interrupt_dispatch #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8,
  parameter logic [15:0] IF_ADDR       = 16'hFF0F,
  parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
  input  logic I_CLOCK,
  input  logic I_RESET,
  interrupt_dispatch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SPDEC,
    S_PUSHHI,
    S_PUSHLO,
    S_JUMP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic        ime_q, ime_d;
  logic        ei_pending_q, ei_pending_d;
  logic [15:0] vector_q, vector_d;
  logic        sp_dec_q, sp_dec_d;
  logic        push_hi_q, push_hi_d;
  logic        push_lo_q, push_lo_d;
  logic        load_pc_q, load_pc_d;
  logic        hold_q, hold_d;
  logic [4:0]  ack_q, ack_d;

  logic        wr_if, wr_ie;
  logic [4:0]  pending_now;
  logic [4:0]  pending_sel;
  logic        accept;
  logic        select;
  logic [2:0]  sel_idx;
  logic [4:0]  clr_mask;

  // Lowest set bit wins; scanning from the top lets the lowest overwrite.
  function automatic logic [2:0] lowest_idx(input logic [4:0] p);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (p[i-1]) r = 3'(i - 1);
    end
    return r;
  endfunction

  // Next-state computation for registers, IME sequencing and the dispatch FSM.
  always_comb begin
    wr_if = !bus.I_MEM_WE_L && (bus.I_CPU_ADDR == IF_ADDR);
    wr_ie = !bus.I_MEM_WE_L && (bus.I_CPU_ADDR == IE_ADDR);

    ie_d = wr_ie ? bus.I_CPU_DATA : ie_q;

    pending_now = if_q & ie_q[4:0];
    // Vector selection sees an IE write landing in the same clock, so a
    // high-byte push onto IE_ADDR can cancel the dispatch.
    pending_sel = if_q & ie_d[4:0];
    sel_idx     = lowest_idx(pending_sel);

    accept = (state_q == S_IDLE) && bus.I_MCYCLE_EN && bus.I_BOUNDARY &&
             ime_q && (|pending_now);
    select = (state_q == S_PUSHHI) && bus.I_MCYCLE_EN;

    // Vector / acknowledge
    clr_mask = '0;
    ack_d    = '0;
    vector_d = vector_q;
    if (select) begin
      if (|pending_sel) begin
        clr_mask = 5'(5'd1 << sel_idx);
        ack_d    = clr_mask;
        vector_d = VECTOR_BASE + 16'(VECTOR_STRIDE * 32'(sel_idx));
      end else begin
        vector_d = '0;
      end
    end

    // IF: write, then dispatch clear, then new requests (set wins)
    if_d = ((wr_if ? bus.I_CPU_DATA[4:0] : if_q) & ~clr_mask) | bus.I_IRQ;

    // IME / delayed EI
    ime_d        = ime_q;
    ei_pending_d = ei_pending_q;
    if (ei_pending_q && bus.I_MCYCLE_EN && bus.I_BOUNDARY) begin
      ime_d        = 1'b1;
      ei_pending_d = 1'b0;
    end
    if ((state_q == S_IDLE) && bus.I_RETI) ime_d = 1'b1;
    if ((state_q == S_IDLE) && bus.I_EI)   ei_pending_d = 1'b1;
    if (bus.I_DI) begin
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end
    if (accept) ime_d = 1'b0;

    // Dispatch sequence
    state_d = state_q;
    if (bus.I_MCYCLE_EN) begin
      unique case (state_q)
        S_IDLE:   if (accept) state_d = S_WAIT;
        S_WAIT:   state_d = S_SPDEC;
        S_SPDEC:  state_d = S_PUSHHI;
        S_PUSHHI: state_d = S_PUSHLO;
        S_PUSHLO: state_d = S_JUMP;
        S_JUMP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    // Strobes are registered decodes of the state being entered
    sp_dec_d  = (state_d == S_SPDEC);
    push_hi_d = (state_d == S_PUSHHI);
    push_lo_d = (state_d == S_PUSHLO);
    load_pc_d = (state_d == S_JUMP);
    hold_d    = (state_d != S_IDLE);
  end

  // State and registered outputs; asynchronous reset returns everything to idle.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q      <= S_IDLE;
      if_q         <= '0;
      ie_q         <= '0;
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
      vector_q     <= '0;
      sp_dec_q     <= 1'b0;
      push_hi_q    <= 1'b0;
      push_lo_q    <= 1'b0;
      load_pc_q    <= 1'b0;
      hold_q       <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      if_q         <= if_d;
      ie_q         <= ie_d;
      ime_q        <= ime_d;
      ei_pending_q <= ei_pending_d;
      vector_q     <= vector_d;
      sp_dec_q     <= sp_dec_d;
      push_hi_q    <= push_hi_d;
      push_lo_q    <= push_lo_d;
      load_pc_q    <= load_pc_d;
      hold_q       <= hold_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.O_IF       = {3'b111, if_q};
  assign bus.O_IE       = ie_q;
  assign bus.O_IME      = ime_q;
  assign bus.O_WAKE     = |(if_q & ie_q[4:0]);
  assign bus.O_CPU_HOLD = hold_q;
  assign bus.O_SP_DEC   = sp_dec_q;
  assign bus.O_PUSH_HI  = push_hi_q;
  assign bus.O_PUSH_LO  = push_lo_q;
  assign bus.O_LOAD_PC  = load_pc_q;
  assign bus.O_VECTOR   = vector_q;
  assign bus.O_ACK      = ack_q;

endmodule
